// File: rtl/svm_seq_pkg.sv
// Shared types, constants and width helpers for the sequential OvO SVM engine.
package svm_seq_pkg;

    // Pairwise evaluations per inference in the 3-class one-vs-one scheme.
    localparam int N_EVAL = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width that stays at least one bit for degenerate counts.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator wide enough that the full dot product can never overflow.
    function automatic int acc_width(input int nf, input int fw, input int ww);
        return ww + fw + $clog2(nf) + 1;
    endfunction

    // Decision sum: one bit beyond the wider of accumulator and bias.
    function automatic int sum_width(input int aw, input int bw);
        return ((aw > bw) ? aw : bw) + 1;
    endfunction

    // Low bit of element idx in a flat packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/svm_seq_engine_if.sv
// Picker <-> engine handshake and data bus.
interface svm_seq_engine_if #(
    parameter int N_features   = 21,
    parameter int featureWidth = 4,
    parameter int weightWidth  = 8,
    parameter int biasWidth    = 12
);
    logic                                       start;
    logic        [featureWidth*N_features-1:0]  features;
    logic signed [weightWidth*N_features-1:0]   weight;
    logic signed [biasWidth-1:0]                bia;
    logic                                       w_class;
    logic                                       svmready;
    logic                                       busy;

    // Picker side: requests inferences and supplies pair coefficients.
    modport master (
        output start, features, weight, bia,
        input  w_class, svmready, busy
    );

    // Engine side.
    modport slave (
        input  start, features, weight, bia,
        output w_class, svmready, busy
    );
endinterface

// File: rtl/svm_mac_unit.sv
// Single-multiplier multiply-accumulate: acc += zext(feature[k]) * sext(weight[k]).
module svm_mac_unit
    import svm_seq_pkg::*;
#(
    parameter int N_features   = 21,
    parameter int featureWidth = 4,
    parameter int weightWidth  = 8,
    parameter int ACC_W        = acc_width(N_features, featureWidth, weightWidth),
    parameter int K_W          = cnt_width(N_features)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear,
    input  logic                                     en,
    input  logic        [K_W-1:0]                    k,
    input  logic        [featureWidth*N_features-1:0] features,
    input  logic signed [weightWidth*N_features-1:0]  weight,
    output logic signed [ACC_W-1:0]                   acc_next
);
    localparam int PROD_W = featureWidth + weightWidth + 1;

    logic signed [featureWidth:0]  feat_s;
    logic signed [weightWidth-1:0] wgt_s;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc_q, acc_d;

    // Select the k-th feature/weight pair and form the running sum.
    always_comb begin
        feat_s   = {1'b0, features[slice_lo(int'(k), featureWidth) +: featureWidth]};
        wgt_s    = weight[slice_lo(int'(k), weightWidth) +: weightWidth];
        prod     = feat_s * wgt_s;
        acc_next = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = clear ? '0 : (en ? acc_next : acc_q);
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always written with <= so every flop sees pre-edge values.
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/svm_seq_engine.sv
// Sequential one-vs-one SVM engine: latches a feature vector, evaluates N_EVAL
// pairwise classifiers one feature per cycle, pulses svmready per decision.
module svm_seq_engine
    import svm_seq_pkg::*;
#(
    parameter int N_features   = 21,
    parameter int featureWidth = 4,
    parameter int weightWidth  = 8,
    parameter int biasWidth    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    svm_seq_engine_if.slave    bus
);
    localparam int ACC_W = acc_width(N_features, featureWidth, weightWidth);
    localparam int SUM_W = sum_width(ACC_W, biasWidth);
    localparam int K_W   = cnt_width(N_features);
    localparam int E_W   = cnt_width(N_EVAL);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MAC  = MAC;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [K_W-1:0]         K_LAST    = K_W'(N_features - 1);
    localparam logic [E_W-1:0]         EVAL_LAST = E_W'(N_EVAL - 1);
    localparam logic signed [SUM_W-1:0] ZERO     = '0;

    logic [1:0]                          state_q, state_d;
    logic [K_W-1:0]                      k_q, k_d;
    logic [E_W-1:0]                      eval_q, eval_d;
    logic [featureWidth*N_features-1:0]  feat_q, feat_d;
    logic                                w_class_q, w_class_d;
    logic                                svmready_q, svmready_d;
    logic                                acc_clr, acc_en;
    logic signed [ACC_W-1:0]             acc_next;
    logic signed [SUM_W-1:0]             sum;

    svm_mac_unit #(
        .N_features  (N_features),
        .featureWidth(featureWidth),
        .weightWidth (weightWidth),
        .ACC_W       (ACC_W),
        .K_W         (K_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clr),
        .en      (acc_en),
        .k       (k_q),
        .features(feat_q),
        .weight  (bus.weight),
        .acc_next(acc_next)
    );

    // FSM, counters and decision: next-state logic.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        k_d        = k_q;
        eval_d     = eval_q;
        feat_d     = feat_q;
        w_class_d  = w_class_q;
        svmready_d = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        sum = {{(SUM_W-ACC_W){acc_next[ACC_W-1]}}, acc_next}
            + {{(SUM_W-biasWidth){bus.bia[biasWidth-1]}}, bus.bia};
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    feat_d  = bus.features;
                    acc_clr = 1'b1;
                    k_d     = '0;
                    eval_d  = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_en = 1'b1;
                k_d    = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    w_class_d  = (sum < ZERO);
                    svmready_d = 1'b1;
                    k_d        = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (eval_q == EVAL_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    eval_d  = eval_q + E_W'(1);
                    acc_clr = 1'b1;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, feature latch and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            eval_q     <= '0;
            // NOTE: the feature register is a plain register bank, so it is reset like any other flop.
            feat_q     <= '0;
            w_class_q  <= 1'b0;
            svmready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            eval_q     <= eval_d;
            feat_q     <= feat_d;
            w_class_q  <= w_class_d;
            svmready_q <= svmready_d;
        end
    end

    assign bus.w_class  = w_class_q;
    assign bus.svmready = svmready_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_svm_seq_engine.sv
// Self-checking bench: the bench plays the picker and compares every decision
// and handshake cycle against a dot-product reference model.
`timescale 1ns/1ps
module tb_svm_seq_engine;
    import svm_seq_pkg::*;

    localparam int NF = 4;
    localparam int FW = 4;
    localparam int WW = 4;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    svm_seq_engine_if #(.N_features(NF), .featureWidth(FW), .weightWidth(WW), .biasWidth(BW)) bus ();

    svm_seq_engine #(.N_features(NF), .featureWidth(FW), .weightWidth(WW), .biasWidth(BW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
        end
    endtask

    // Reference decision: sign of the plain dot product plus bias.
    function automatic int ref_class(input int f[NF], input int w[NF], input int b);
        int s = b;
        for (int i = 0; i < NF; i++) s += f[i] * w[i];
        return (s < 0) ? 1 : 0;
    endfunction

    function automatic logic [FW*NF-1:0] pack_f(input int f[NF]);
        logic [FW*NF-1:0] v = '0;
        for (int i = 0; i < NF; i++) v[i*FW +: FW] = FW'(f[i]);
        return v;
    endfunction

    function automatic logic [WW*NF-1:0] pack_w(input int w[NF]);
        logic [WW*NF-1:0] v = '0;
        for (int i = 0; i < NF; i++) v[i*WW +: WW] = WW'(w[i]);
        return v;
    endfunction

    // One inference; caller is positioned at a negedge (cycle 0).
    // mode 0: single start pulse; 1: stray starts + feature change; 2: start held high.
    task automatic run_inf(input int f[NF], input int w0[NF], input int b0,
                           input int w1[NF], input int b1, input int mode);
        int exp0, exp1, pulses;
        exp0   = ref_class(f, w0, b0);
        exp1   = ref_class(f, w1, b1);
        pulses = 0;
        bus.features = pack_f(f);
        bus.weight   = pack_w(w0);
        bus.bia      = BW'(b0);
        bus.start    = 1'b1;
        for (int c = 1; c <= 2*NF+3; c++) begin
            @(negedge clk);
            if (bus.svmready) pulses++;
            if (c == NF+1) begin
                check("svmready_eval1", int'(bus.svmready), 1);
                check("w_class_eval1", int'(bus.w_class), exp0);
            end else if (c == 2*NF+2) begin
                check("svmready_eval2", int'(bus.svmready), 1);
                check("w_class_eval2", int'(bus.w_class), exp1);
            end else begin
                check("svmready_idle", int'(bus.svmready), 0);
            end
            check("busy", int'(bus.busy), (c <= 2*NF+2) ? 1 : 0);
            if (mode != 2) begin
                if (c == 1) bus.start = 1'b0;
                if (mode == 1) begin
                    if (c == 1) bus.features = ~pack_f(f);
                    if (c == 2 || c == 6) bus.start = 1'b1;
                    if (c == 3 || c == 7) bus.start = 1'b0;
                end
            end
            if (c == NF+1) begin
                bus.weight = pack_w(w1);
                bus.bia    = BW'(b1);
            end
        end
        check("pulse_count", pulses, 2);
    endtask

    initial begin
        int f[NF], wa[NF], wb[NF], ws[NF];
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.features = '0;
        bus.weight   = '0;
        bus.bia      = '0;
        #12;
        check("rst_svmready", int'(bus.svmready), 0);
        check("rst_w_class", int'(bus.w_class), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-pair inference: tie then negative sum.
        f  = '{1, 2, 3, 4};
        wa = '{1, 1, 1, 1};
        wb = '{-1, -1, -1, -1};
        run_inf(f, wa, -10, wb, 0, 0);

        // Extremes: largest negative and positive sums.
        f  = '{15, 15, 15, 15};
        wa = '{-8, -8, -8, -8};
        wb = '{7, 7, 7, 7};
        run_inf(f, wa, -128, wb, 127, 0);

        // Stray starts are ignored and the latched vector is used.
        f  = '{1, 2, 3, 4};
        wa = '{-1, -1, -1, -1};
        wb = '{1, 1, 1, 1};
        run_inf(f, wa, 12, wb, -12, 1);

        // Back-to-back: held start launches the next inference at cycle 2*NF+3.
        run_inf(f, wa, 12, wb, -12, 2);
        f = '{15, 0, 7, 3};
        run_inf(f, wb, -20, wa, 20, 0);

        // Reset in the middle of a decision pulse.
        f  = '{15, 15, 15, 15};
        ws = '{-8, -8, -8, -8};
        bus.features = pack_f(f);
        bus.weight   = pack_w(ws);
        bus.bia      = -8'sd128;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (NF) @(negedge clk);
        check("pre_rst_svmready", int'(bus.svmready), 1);
        check("pre_rst_w_class", int'(bus.w_class), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_svmready", int'(bus.svmready), 0);
        check("async_rst_w_class", int'(bus.w_class), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f  = '{1, 2, 3, 4};
        wa = '{1, 1, 1, 1};
        wb = '{-1, -1, -1, -1};
        run_inf(f, wa, -10, wb, 0, 0);

        // Randomized inferences with mixed start behaviour.
        for (int it = 0; it < 40; it++) begin
            int ba, bb;
            for (int i = 0; i < NF; i++) begin
                f[i]  = int'($urandom_range(0, 15));
                wa[i] = int'($urandom_range(0, 15)) - 8;
                wb[i] = int'($urandom_range(0, 15)) - 8;
            end
            ba = int'($urandom_range(0, 255)) - 128;
            bb = int'($urandom_range(0, 255)) - 128;
            run_inf(f, wa, ba, wb, bb, int'($urandom_range(0, 2)));
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("final_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
